note_sequencer: RTL
===================

# note_sequencer

Parametrised record/playback engine for keyboard note events, the successor to the fixed 16-note control/datapath recorder. It sits between the keyboard-code converter and the frequency datapath. It stores key-down/key-up events with inter-event timing in a DEPTH-entry buffer and replays them with the original rhythm, optionally looping. Its outputs are the currently sounding note/octave and a gate, which feed the note-to-frequency lookup.

## Interface
- DEPTH, 16: event buffer entries (power of two, ≥2)
- NOTE_W, 4: note code width
- OCT_W, 2: octave code width
- DUR_W, 12: delta-time field width, in ticks
- TICK_DIV, 500000: CLOCK_50 cycles per tick (10 ms); ≥2
- CLOCK_50  in  1  sole clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- rec_start  in  1  pulse: begin recording (clears buffer)
- play_start  in  1  pulse: begin playback from entry 0
- stop  in  1  pulse: end record/playback, return to IDLE
- loop_en  in  1  level: restart playback after last entry
- ev_valid  in  1  one-cycle key event strobe
- ev_down  in  1  1 = key pressed, 0 = released
- ev_note  in  NOTE_W  note code of event
- ev_octave  in  OCT_W  octave code of event
- gate  out  1  note sounding
- out_note  out  NOTE_W  current note
- out_octave  out  OCT_W  current octave
- state  out  2  0 IDLE, 1 RECORD, 2 PLAY
- count  out  $clog2(DEPTH)+1  stored entries
- overflow  out  1  sticky: event dropped while full
- done  out  1  one-cycle pulse at end of non-looping playback

## Operation
- Reset: state IDLE, gate 0, out_note 0, out_octave 0, count 0, overflow 0, done 0, tick counter 0. Buffer contents don't-care.
- Entry format: {down, note, octave, delta[DUR_W-1:0]}.
- Command priority within one cycle: stop > rec_start > play_start. Starts are honoured only in IDLE and ignored elsewhere.
- IDLE: gate 0. ev_* ignored.
- rec_start → RECORD: count 0, overflow 0, delta counter 0, tick counter 0.
- RECORD: the delta counter increments on each tick and saturates at 2^DUR_W−1.
  - On ev_valid with count<DEPTH: write {ev_down, ev_note, ev_octave, delta} at index count, count+1, delta counter cleared. If a tick coincides, the counter becomes 0, not 1.
  - On ev_valid with count==DEPTH: event dropped, overflow←1.
  - An ev_valid in the same cycle as rec_start is not recorded.
  - gate/out_* are not driven from live input; they hold 0.
- play_start with count==0: done pulses next cycle, state stays IDLE.
- play_start with count>0 → PLAY: ptr 0, wait counter 0, tick counter 0.
- PLAY: wait increments per tick.
  - When wait==entry[ptr].delta, apply the entry: gate←down, out_note←note, out_octave←octave; ptr+1; wait←0.
  - Delta 0 applies on the cycle of the check, with no tick needed.
  - After applying the entry at index count−1:
    - If loop_en=1: ptr←0, wait←0, continue.
    - If loop_en=0: state←IDLE, gate←0, done pulses.
- stop in RECORD or PLAY → IDLE next cycle. gate←0, count and buffer retained.
- A reset mid-operation overrides all of the above.

## Timing
- Tick: single-cycle internal strobe when the divider reaches TICK_DIV−1. The divider restarts at 0 on every mode entry.
- Command to state change: 1 cycle. A start pulse at edge N gives state updated after edge N.
- Record write: the ev_valid cycle. count visible +1 on the next cycle.
- Playback apply: outputs update on the edge following the cycle where the match is true; ptr is combinationally read from the register array.
- The first entry with delta d is applied d ticks after PLAY entry (d=0: 1 cycle after entry).
- Loop wrap adds no extra cycles beyond the next entry's delta.
- done: exactly one cycle, coincident with state returning to IDLE.

## Structure
- Shared package music_pkg: NOTE_W/OCT_W defaults, state encoding constants (ST_IDLE, ST_RECORD, ST_PLAY), entry packing helper/typedef.
- Sub-module tick_divider (parameter TICK_DIV; inputs CLOCK_50, reset, clear; output tick).
- Buffer implemented as a register array. Do not infer RAM; the combinational read is required.

## Test plan
Benches use TICK_DIV=4, DUR_W=4, DEPTH=4.
- Reset check: assert reset mid-PLAY → next cycle state 0, gate 0, count 0, overflow 0.
- Record/play: record down C(3)/oct1 at 2 ticks, up at 5 ticks → count 2, entries delta 2 and 3. Play → gate rises 8 cycles (+1) after entry, falls 12 cycles later, done pulses, state 0.
- Overflow: record 5 events with DEPTH=4 → count 4, overflow 1. The 5th event is absent in playback.
- Delta saturation: wait 20 ticks before the first event → stored delta 15.
- Loop: loop_en=1 with 2 entries → pattern repeats ≥3 times, no done. stop → gate 0 next cycle, state 0, count still 2.
- Priority and empty play:
  - stop+rec_start same cycle in IDLE → stays IDLE.
  - rec_start+play_start → RECORD.
  - play_start with count 0 → done pulse, state 0.

Source files
------------

// File: rtl/music_pkg.sv
// Shared definitions for the note record/playback path: default code widths,
// sequencer state encoding and the stored event entry layout.
package music_pkg;

  localparam int NOTE_W_DEF = 4;
  localparam int OCT_W_DEF  = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RECORD = 2'd1;
  localparam logic [1:0] ST_PLAY   = 2'd2;

  // Stored entry is {down, note, octave, delta}; this gives its total width.
  function automatic int entry_width(input int note_w, input int oct_w, input int dur_w);
    return 1 + note_w + oct_w + dur_w;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Divides CLOCK_50 down to a single-cycle tick strobe every TICK_DIV cycles.
// clear restarts the count so a new mode always sees a full first tick period.
module tick_divider #(
  parameter int TICK_DIV = 500000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == LAST);

  // Free-running modulo-TICK_DIV counter, restarted by reset or clear.
  always_ff @(posedge CLOCK_50) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Record/playback engine for keyboard note events. Records key events with
// tick-resolution inter-event timing into a small register array and replays
// them with the same rhythm, optionally looping, driving note/octave/gate.
module note_sequencer
  import music_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int NOTE_W   = NOTE_W_DEF,
  parameter int OCT_W    = OCT_W_DEF,
  parameter int DUR_W    = 12,
  parameter int TICK_DIV = 500000
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     rec_start,
  input  logic                     play_start,
  input  logic                     stop,
  input  logic                     loop_en,
  input  logic                     ev_valid,
  input  logic                     ev_down,
  input  logic [NOTE_W-1:0]        ev_note,
  input  logic [OCT_W-1:0]         ev_octave,
  output logic                     gate,
  output logic [NOTE_W-1:0]        out_note,
  output logic [OCT_W-1:0]         out_octave,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     done
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = entry_width(NOTE_W, OCT_W, DUR_W);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Delta counter saturates rather than wrapping so long pauses stay long.
  function automatic logic [DUR_W-1:0] sat_inc(input logic [DUR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic              gate_q, gate_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [OCT_W-1:0]  oct_q, oct_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [DUR_W-1:0]  wait_q, wait_d;
  logic [DUR_W-1:0]  delta_q, delta_d;
  logic              wr_en;
  logic              div_clr;
  logic              tick;

  logic [ENTRY_W-1:0] buf_q [DEPTH];
  logic [ENTRY_W-1:0] rd_entry;
  logic               rd_down;
  logic [NOTE_W-1:0]  rd_note;
  logic [OCT_W-1:0]   rd_oct;
  logic [DUR_W-1:0]   rd_delta;
  logic               last_entry;

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .clear    (div_clr),
    .tick     (tick)
  );

  // Playback reads the current entry combinationally from the register array.
  assign rd_entry   = buf_q[ptr_q];
  assign rd_down    = rd_entry[ENTRY_W-1];
  assign rd_note    = rd_entry[ENTRY_W-2 -: NOTE_W];
  assign rd_oct     = rd_entry[DUR_W +: OCT_W];
  assign rd_delta   = rd_entry[DUR_W-1:0];
  assign last_entry = ({1'b0, ptr_q} == (count_q - 1'b1));

  // Next-state logic: stop beats rec_start beats play_start; starts only from IDLE.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    gate_d  = gate_q;
    note_d  = note_q;
    oct_d   = oct_q;
    ptr_d   = ptr_q;
    wait_d  = wait_q;
    delta_d = delta_q;
    wr_en   = 1'b0;
    div_clr = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
      gate_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          gate_d = 1'b0;
          if (rec_start) begin
            state_d = ST_RECORD;
            count_d = '0;
            ovf_d   = 1'b0;
            delta_d = '0;
            note_d  = '0;
            oct_d   = '0;
            div_clr = 1'b1;
          end else if (play_start) begin
            if (count_q == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = ST_PLAY;
              ptr_d   = '0;
              wait_d  = '0;
              div_clr = 1'b1;
            end
          end
        end
        ST_RECORD: begin
          if (tick) delta_d = sat_inc(delta_q);
          if (ev_valid) begin
            if (count_q < DEPTH_C) begin
              wr_en   = 1'b1;
              count_d = count_q + 1'b1;
              delta_d = '0;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
        ST_PLAY: begin
          if (wait_q == rd_delta) begin
            gate_d = rd_down;
            note_d = rd_note;
            oct_d  = rd_oct;
            wait_d = '0;
            if (last_entry) begin
              ptr_d = '0;
              if (!loop_en) begin
                state_d = ST_IDLE;
                gate_d  = 1'b0;
                done_d  = 1'b1;
              end
            end else begin
              ptr_d = ptr_q + 1'b1;
            end
          end else if (tick) begin
            wait_d = wait_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control and output registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      gate_q  <= 1'b0;
      note_q  <= '0;
      oct_q   <= '0;
      ptr_q   <= '0;
      wait_q  <= '0;
      delta_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      gate_q  <= gate_d;
      note_q  <= note_d;
      oct_q   <= oct_d;
      ptr_q   <= ptr_d;
      wait_q  <= wait_d;
      delta_q <= delta_d;
    end
  end

  // Event buffer write; contents are not reset.
  always_ff @(posedge CLOCK_50) begin
    if (wr_en) buf_q[count_q[PTR_W-1:0]] <= {ev_down, ev_note, ev_octave, delta_q};
  end

  assign gate       = gate_q;
  assign out_note   = note_q;
  assign out_octave = oct_q;
  assign state      = state_q;
  assign count      = count_q;
  assign overflow   = ovf_q;
  assign done       = done_q;

endmodule
